// File: rtl/spi_triangle_loader_if.sv
// Port-B register bank bus between the triangle loader (master) and the SPI register bank (slave).
interface spi_triangle_loader_if;
    logic [3:0]  o_reg_addr;
    logic        o_reg_wr_en;
    logic [31:0] o_reg_wr_data;
    logic [31:0] i_reg_rd_data;

    modport master (
        output o_reg_addr,
        output o_reg_wr_en,
        output o_reg_wr_data,
        input  i_reg_rd_data
    );

    modport slave (
        input  o_reg_addr,
        input  o_reg_wr_en,
        input  o_reg_wr_data,
        output i_reg_rd_data
    );
endinterface

// File: rtl/spi_triangle_loader.sv
// Polls the SPI register bank for a host-posted triangle, clamps and validates it, commits it to
// the rasterizer only while the raster is idle, and acknowledges through the CTRL register.
module spi_triangle_loader #(
    parameter int unsigned HORIZ_RESOLUTION = 80,
    parameter int unsigned VERT_RESOLUTION  = 60,
    parameter int unsigned RD_LATENCY       = 2,
    parameter int unsigned POLL_INTERVAL    = 1024
) (
    input  logic                                 i_clk,
    input  logic                                 i_srst,
    spi_triangle_loader_if.master                reg_bus,
    input  logic                                 i_raster_busy,
    output logic [$clog2(HORIZ_RESOLUTION)-1:0]  o_p0_x,
    output logic [$clog2(HORIZ_RESOLUTION)-1:0]  o_p1_x,
    output logic [$clog2(HORIZ_RESOLUTION)-1:0]  o_p2_x,
    output logic [$clog2(VERT_RESOLUTION)-1:0]   o_p0_y,
    output logic [$clog2(VERT_RESOLUTION)-1:0]   o_p1_y,
    output logic [$clog2(VERT_RESOLUTION)-1:0]   o_p2_y,
    output logic                                 o_tri_update,
    output logic [3:0]                           o_led
);

    localparam int unsigned XW = $clog2(HORIZ_RESOLUTION);
    localparam int unsigned YW = $clog2(VERT_RESOLUTION);
    localparam int unsigned PW = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
    localparam int unsigned AW = (XW + YW + 3 > 18) ? (XW + YW + 3) : 18;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_RD_CTRL   = 3'd1;
    localparam logic [2:0] ST_RD_V0     = 3'd2;
    localparam logic [2:0] ST_RD_V1     = 3'd3;
    localparam logic [2:0] ST_RD_V2     = 3'd4;
    localparam logic [2:0] ST_CHECK     = 3'd5;
    localparam logic [2:0] ST_WAIT_IDLE = 3'd6;
    localparam logic [2:0] ST_ACK       = 3'd7;

    logic [2:0]           state_q, state_d;
    logic [PW-1:0]        poll_cnt_q, poll_cnt_d;
    logic [1:0]           rd_cnt_q, rd_cnt_d;
    logic [3:0]           addr_q, addr_d;
    logic                 wr_en_q, wr_en_d;
    logic [31:0]          wr_data_q, wr_data_d;
    logic [31:4]          ctrl_q, ctrl_d;
    logic                 err_q, err_d;
    logic [2:0][XW-1:0]   cx_q, cx_d;
    logic [2:0][YW-1:0]   cy_q, cy_d;
    logic [2:0][XW-1:0]   px_q, px_d;
    logic [2:0][YW-1:0]   py_q, py_d;
    logic                 upd_q, upd_d;

    logic signed [AW-1:0] dx1_c, dy1_c, dx2_c, dy2_c, area_c;
    logic [31:0]          rd_data_c;

    // Clamp on the full 16-bit register field before truncating to the raster width.
    function automatic logic [XW-1:0] clamp_x(input logic [15:0] v);
        if (v >= 16'(HORIZ_RESOLUTION)) return XW'(HORIZ_RESOLUTION - 1);
        return v[XW-1:0];
    endfunction

    function automatic logic [YW-1:0] clamp_y(input logic [15:0] v);
        if (v >= 16'(VERT_RESOLUTION)) return YW'(VERT_RESOLUTION - 1);
        return v[YW-1:0];
    endfunction

    assign rd_data_c = reg_bus.i_reg_rd_data;

    // Twice the signed triangle area; zero means degenerate (collinear or coincident vertices).
    always_comb begin
        dx1_c  = AW'(cx_q[1]) - AW'(cx_q[0]);
        dy1_c  = AW'(cy_q[1]) - AW'(cy_q[0]);
        dx2_c  = AW'(cx_q[2]) - AW'(cx_q[0]);
        dy2_c  = AW'(cy_q[2]) - AW'(cy_q[0]);
        area_c = dx1_c * dy2_c - dx2_c * dy1_c;
    end

    always_comb begin
        state_d    = state_q;
        poll_cnt_d = poll_cnt_q;
        rd_cnt_d   = rd_cnt_q;
        addr_d     = addr_q;
        wr_en_d    = 1'b0;
        wr_data_d  = wr_data_q;
        ctrl_d     = ctrl_q;
        err_d      = err_q;
        cx_d       = cx_q;
        cy_d       = cy_q;
        px_d       = px_q;
        py_d       = py_q;
        upd_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (poll_cnt_q == PW'(POLL_INTERVAL - 1)) begin
                    poll_cnt_d = '0;
                    rd_cnt_d   = '0;
                    addr_d     = 4'd0;
                    state_d    = ST_RD_CTRL;
                end else begin
                    poll_cnt_d = poll_cnt_q + PW'(1);
                end
            end
            ST_RD_CTRL: begin
                if (rd_cnt_q == 2'(RD_LATENCY)) begin
                    rd_cnt_d = '0;
                    ctrl_d   = rd_data_c[31:4];
                    if (rd_data_c[0] && !rd_data_c[1]) begin
                        addr_d  = 4'd1;
                        state_d = ST_RD_V0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    rd_cnt_d = rd_cnt_q + 2'd1;
                end
            end
            ST_RD_V0, ST_RD_V1, ST_RD_V2: begin
                if (rd_cnt_q == 2'(RD_LATENCY)) begin
                    rd_cnt_d = '0;
                    if (state_q == ST_RD_V0) begin
                        cx_d[0] = clamp_x(rd_data_c[15:0]);
                        cy_d[0] = clamp_y(rd_data_c[31:16]);
                    end else if (state_q == ST_RD_V1) begin
                        cx_d[1] = clamp_x(rd_data_c[15:0]);
                        cy_d[1] = clamp_y(rd_data_c[31:16]);
                    end else begin
                        cx_d[2] = clamp_x(rd_data_c[15:0]);
                        cy_d[2] = clamp_y(rd_data_c[31:16]);
                    end
                    if (state_q == ST_RD_V2) begin
                        state_d = ST_CHECK;
                    end else begin
                        addr_d  = addr_q + 4'd1;
                        state_d = state_q + 3'd1;
                    end
                end else begin
                    rd_cnt_d = rd_cnt_q + 2'd1;
                end
            end
            ST_CHECK: begin
                err_d   = (area_c == '0);
                state_d = (area_c == '0) ? ST_ACK : ST_WAIT_IDLE;
            end
            ST_WAIT_IDLE: begin
                // All six coordinates move together so the rasterizer never sees a mixed triangle.
                if (!i_raster_busy) begin
                    px_d    = cx_q;
                    py_d    = cy_q;
                    upd_d   = 1'b1;
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                wr_en_d    = 1'b1;
                addr_d     = 4'd0;
                wr_data_d  = {ctrl_q, 1'b0, err_q, 1'b1, 1'b0};
                poll_cnt_d = '0;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            state_q    <= ST_IDLE;
            poll_cnt_q <= '0;
            rd_cnt_q   <= '0;
            addr_q     <= '0;
            wr_en_q    <= 1'b0;
            wr_data_q  <= '0;
            ctrl_q     <= '0;
            err_q      <= 1'b0;
            cx_q       <= '0;
            cy_q       <= '0;
            px_q       <= {XW'(25), XW'(50), XW'(10)};
            py_q       <= {YW'(50), YW'(10), YW'(10)};
            upd_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            poll_cnt_q <= poll_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            addr_q     <= addr_d;
            wr_en_q    <= wr_en_d;
            wr_data_q  <= wr_data_d;
            ctrl_q     <= ctrl_d;
            err_q      <= err_d;
            cx_q       <= cx_d;
            cy_q       <= cy_d;
            px_q       <= px_d;
            py_q       <= py_d;
            upd_q      <= upd_d;
        end
    end

    assign reg_bus.o_reg_addr    = addr_q;
    assign reg_bus.o_reg_wr_en   = wr_en_q;
    assign reg_bus.o_reg_wr_data = wr_data_q;
    assign o_p0_x       = px_q[0];
    assign o_p1_x       = px_q[1];
    assign o_p2_x       = px_q[2];
    assign o_p0_y       = py_q[0];
    assign o_p1_y       = py_q[1];
    assign o_p2_y       = py_q[2];
    assign o_tri_update = upd_q;
    assign o_led        = ctrl_q[7:4];

endmodule

// File: tb/tb_spi_triangle_loader.sv
// Bench for spi_triangle_loader: two instances (read latency 2 and 1) each with a register-bank
// model, driven by directed and random triangle posts and checked against a geometric model.
module tb_spi_triangle_loader;

    localparam int unsigned POLL = 20;

    logic        clk      = 1'b0;
    logic        srst     = 1'b1;
    logic        busy     = 1'b0;
    logic        post_req = 1'b0;
    logic [31:0] post_words [4];
    int          cyc      = 0;

    logic [6:0]  px     [2][3];
    logic [5:0]  py     [2][3];
    logic        upd    [2];
    logic        wen    [2];
    logic [3:0]  addr_o [2];
    logic [3:0]  led    [2];
    logic [31:0] wdata  [2];

    int          n_upd [2] = '{0, 0};
    int          n_wr  [2] = '{0, 0};
    int          t_v0  [2] = '{0, 0};
    int          t_v1  [2] = '{0, 0};
    int          t_v2  [2] = '{0, 0};
    int          t_upd [2] = '{0, 0};
    int          t_wr  [2] = '{0, 0};
    logic [31:0] last_wdata [2];
    logic [3:0]  last_waddr [2];
    logic [3:0]  prev_addr  [2] = '{4'd0, 4'd0};

    int          n_chk = 0;
    int          n_err = 0;
    int          cur_x [3];
    int          cur_y [3];
    int          ex    [3];
    int          ey    [3];
    bit          eerr;
    logic [31:0] ewr;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int unsigned LAT = (g == 0) ? 2 : 1;
        spi_triangle_loader_if bus ();
        logic [31:0] mem  [4];
        logic [31:0] pipe [2];

        spi_triangle_loader #(
            .HORIZ_RESOLUTION (80),
            .VERT_RESOLUTION  (60),
            .RD_LATENCY       (LAT),
            .POLL_INTERVAL    (POLL)
        ) u_dut (
            .i_clk         (clk),
            .i_srst        (srst),
            .reg_bus       (bus.master),
            .i_raster_busy (busy),
            .o_p0_x        (px[g][0]),
            .o_p1_x        (px[g][1]),
            .o_p2_x        (px[g][2]),
            .o_p0_y        (py[g][0]),
            .o_p1_y        (py[g][1]),
            .o_p2_y        (py[g][2]),
            .o_tri_update  (upd[g]),
            .o_led         (led[g])
        );

        // Register bank port B: host posts win; reads return data LAT cycles after the address.
        always @(posedge clk) begin
            if (post_req) begin
                for (int i = 0; i < 4; i++) mem[i] <= post_words[i];
            end else if (bus.o_reg_wr_en) begin
                mem[bus.o_reg_addr[1:0]] <= bus.o_reg_wr_data;
            end
            pipe[0] <= mem[bus.o_reg_addr[1:0]];
            pipe[1] <= pipe[0];
        end

        assign bus.i_reg_rd_data = pipe[LAT-1];
        assign wen[g]    = bus.o_reg_wr_en;
        assign addr_o[g] = bus.o_reg_addr;
        assign wdata[g]  = bus.o_reg_wr_data;
    end

    // Event recorder, sampled mid-cycle.
    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (addr_o[g] != prev_addr[g]) begin
                if (addr_o[g] == 4'd1) t_v0[g] <= cyc;
                if (addr_o[g] == 4'd2) t_v1[g] <= cyc;
                if (addr_o[g] == 4'd3) t_v2[g] <= cyc;
            end
            prev_addr[g] <= addr_o[g];
            if (upd[g]) begin
                n_upd[g] <= n_upd[g] + 1;
                t_upd[g] <= cyc;
            end
            if (wen[g]) begin
                n_wr[g]       <= n_wr[g] + 1;
                t_wr[g]       <= cyc;
                last_wdata[g] <= wdata[g];
                last_waddr[g] <= addr_o[g];
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected geometry and acknowledge word for a posted register image.
    task automatic model(input logic [31:0] w [4]);
        int a;
        for (int i = 0; i < 3; i++) begin
            int x;
            int y;
            x = int'(w[i+1][15:0]);
            y = int'(w[i+1][31:16]);
            ex[i] = (x >= 80) ? 79 : x;
            ey[i] = (y >= 60) ? 59 : y;
        end
        a    = (ex[1] - ex[0]) * (ey[2] - ey[0]) - (ex[2] - ex[0]) * (ey[1] - ey[0]);
        eerr = (a == 0);
        ewr  = (w[0] & 32'hFFFF_FFF0) | (eerr ? 32'h4 : 32'h0) | 32'h2;
    endtask

    task automatic post(input logic [31:0] w [4]);
        @(negedge clk);
        post_words = w;
        post_req   = 1'b1;
        @(negedge clk);
        post_req   = 1'b0;
    endtask

    task automatic wait_wr(input int p0, input int p1);
        int k = 0;
        while ((n_wr[0] <= p0 || n_wr[1] <= p1) && k < 400) begin
            @(negedge clk);
            #1;
            k++;
        end
    endtask

    task automatic check_outputs(input string tag);
        for (int g = 0; g < 2; g++) begin
            for (int i = 0; i < 3; i++) begin
                check_eq($sformatf("%s_p%0d_x[%0d]", tag, i, g), 32'(px[g][i]), 32'(cur_x[i]));
                check_eq($sformatf("%s_p%0d_y[%0d]", tag, i, g), 32'(py[g][i]), 32'(cur_y[i]));
            end
        end
    endtask

    task automatic run_tri(input logic [31:0] w [4], input int hold);
        int p_upd [2];
        int p_wr  [2];
        int rel;
        int lat;
        rel = 0;
        model(w);
        for (int g = 0; g < 2; g++) begin
            p_upd[g] = n_upd[g];
            p_wr[g]  = n_wr[g];
        end
        if (hold > 0) busy = 1'b1;
        post(w);
        if (hold > 0) begin
            repeat (hold) @(negedge clk);
            #1;
            for (int g = 0; g < 2; g++) begin
                check_eq($sformatf("upd_while_busy[%0d]", g), n_upd[g], p_upd[g]);
                check_eq($sformatf("wr_while_busy[%0d]", g), n_wr[g], p_wr[g] + (eerr ? 1 : 0));
            end
            @(negedge clk);
            busy = 1'b0;
            rel  = cyc;
        end
        wait_wr(p_wr[0], p_wr[1]);
        if (!eerr) begin
            cur_x = ex;
            cur_y = ey;
        end
        for (int g = 0; g < 2; g++) begin
            lat = (g == 0) ? 2 : 1;
            check_eq($sformatf("upd_count[%0d]", g), n_upd[g], p_upd[g] + (eerr ? 0 : 1));
            check_eq($sformatf("wr_count[%0d]", g), n_wr[g], p_wr[g] + 1);
            check_eq($sformatf("wr_addr[%0d]", g), 32'(last_waddr[g]), 32'd0);
            check_eq($sformatf("wr_data[%0d]", g), last_wdata[g], ewr);
            check_eq($sformatf("led[%0d]", g), 32'(led[g]), 32'(w[0][7:4]));
            check_eq($sformatf("v1_issue[%0d]", g), t_v1[g] - t_v0[g], lat + 1);
            check_eq($sformatf("v2_issue[%0d]", g), t_v2[g] - t_v0[g], 2 * lat + 2);
            if (!eerr) begin
                if (hold > 0)
                    check_eq($sformatf("upd_after_release[%0d]", g), t_upd[g], rel + 1);
                else
                    check_eq($sformatf("commit_latency[%0d]", g), t_upd[g] - t_v0[g], 3 * lat + 5);
                check_eq($sformatf("ack_after_commit[%0d]", g), t_wr[g] - t_upd[g], 1);
            end
        end
        check_outputs("tri");
        repeat (4) @(negedge clk);
    endtask

    task automatic reset_defaults();
        cur_x = '{10, 50, 25};
        cur_y = '{10, 10, 50};
    endtask

    logic [31:0] w [4];

    initial begin
        int p_wr0;
        int p_upd0;
        int p_upd1;
        int k;
        reset_defaults();

        // Clear the bank while the DUTs are held in reset.
        post_words = '{32'h0, 32'h0, 32'h0, 32'h0};
        post_req   = 1'b1;
        repeat (3) @(negedge clk);
        post_req   = 1'b0;
        #1;
        for (int g = 0; g < 2; g++) begin
            check_eq($sformatf("rst_upd[%0d]", g), 32'(upd[g]), 32'd0);
            check_eq($sformatf("rst_wen[%0d]", g), 32'(wen[g]), 32'd0);
            check_eq($sformatf("rst_addr[%0d]", g), 32'(addr_o[g]), 32'd0);
            check_eq($sformatf("rst_wdata[%0d]", g), wdata[g], 32'd0);
            check_eq($sformatf("rst_led[%0d]", g), 32'(led[g]), 32'd0);
        end
        check_outputs("rst");
        @(negedge clk);
        srst = 1'b0;

        // Basic post, then one with an out-of-range vertex, then a degenerate one.
        w = '{32'h31, {16'd5, 16'd5}, {16'd5, 16'd70}, {16'd55, 16'd40}};
        run_tri(w, 0);
        w = '{32'h31, {16'd5, 16'd5}, {16'd90, 16'd200}, {16'd55, 16'd40}};
        run_tri(w, 0);
        w = '{32'h01, {16'd0, 16'd0}, {16'd10, 16'd10}, {16'd20, 16'd20}};
        run_tri(w, 0);

        // Reset in the middle of the V1 read of the latency-2 instance.
        w = '{32'h31, {16'd5, 16'd5}, {16'd5, 16'd70}, {16'd55, 16'd40}};
        p_wr0 = n_wr[0];
        post(w);
        k = 0;
        while (addr_o[0] != 4'd2 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check_eq("reach_rd_v1", 32'(addr_o[0]), 32'd2);
        srst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #1;
            for (int g = 0; g < 2; g++) begin
                check_eq($sformatf("mid_rst_upd[%0d]", g), 32'(upd[g]), 32'd0);
                check_eq($sformatf("mid_rst_wen[%0d]", g), 32'(wen[g]), 32'd0);
            end
        end
        reset_defaults();
        check_outputs("mid_rst");
        check_eq("mid_rst_addr", 32'(addr_o[0]), 32'd0);
        check_eq("mid_rst_no_write", n_wr[0], p_wr0);
        srst = 1'b0;
        run_tri(w, 0);

        // Raster busy across the whole transaction.
        w = '{32'h71, {16'd3, 16'd2}, {16'd12, 16'd60}, {16'd40, 16'd33}};
        run_tri(w, 500);

        // Non-valid and already-done CTRL polls: LED tracks, nothing else moves.
        p_wr0  = n_wr[0];
        p_upd0 = n_upd[0];
        p_upd1 = n_upd[1];
        w = '{32'h50, 32'h0, 32'h0, 32'h0};
        post(w);
        repeat (3 * POLL) @(negedge clk);
        #1;
        check_eq("poll_led0", 32'(led[0]), 32'h5);
        check_eq("poll_led1", 32'(led[1]), 32'h5);
        w = '{32'hA3, {16'd1, 16'd1}, {16'd30, 16'd1}, {16'd1, 16'd30}};
        post(w);
        repeat (3 * POLL) @(negedge clk);
        #1;
        check_eq("done_led0", 32'(led[0]), 32'hA);
        check_eq("done_led1", 32'(led[1]), 32'hA);
        check_eq("poll_no_write", n_wr[0], p_wr0);
        check_eq("poll_no_upd0", n_upd[0], p_upd0);
        check_eq("poll_no_upd1", n_upd[1], p_upd1);

        // Random posts, some with the rasterizer busy for a while.
        for (int it = 0; it < 10; it++) begin
            w[0] = ($urandom & 32'hFFFF_FFFC) | 32'h1;
            for (int i = 1; i < 4; i++)
                w[i] = {16'($urandom_range(0, 90)), 16'($urandom_range(0, 120))};
            run_tri(w, ($urandom_range(0, 2) == 0) ? int'($urandom_range(60, 100)) : 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
